// File: rtl/ysyx_23060332_seq_ctrl_pkg.sv
// Shared types for the NPC multi-cycle sequencer.
// State encoding and halt-cause codes used by the controller and its bench.
package ysyx_23060332_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    SEQ_IF_REQ   = 3'd0,
    SEQ_IF_WAIT  = 3'd1,
    SEQ_EXEC     = 3'd2,
    SEQ_MEM_REQ  = 3'd3,
    SEQ_MEM_WAIT = 3'd4,
    SEQ_WB       = 3'd5,
    SEQ_HALT     = 3'd6
  } seq_state_e;

  typedef enum logic [1:0] {
    HALT_NONE    = 2'd0,
    HALT_EBREAK  = 2'd1,
    HALT_ILLEGAL = 2'd2,
    HALT_TIMEOUT = 2'd3
  } halt_cause_e;

  function automatic logic is_wait_state(input seq_state_e s);
    return (s == SEQ_IF_REQ)  || (s == SEQ_IF_WAIT) ||
           (s == SEQ_MEM_REQ) || (s == SEQ_MEM_WAIT);
  endfunction

endpackage

// File: rtl/ysyx_23060332_wdog.sv
// Bus watchdog: counts stalled cycles in a handshake state.
// Saturates at TIMEOUT; clr restarts the count on every state entry.
module ysyx_23060332_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIM = W'(TIMEOUT);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run && !expired)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIM);

endmodule

// File: rtl/ysyx_23060332_seq_ctrl.sv
// Multi-cycle sequencer: fetch, exec, optional memory, writeback.
// Stops on ebreak, illegal instruction or memory-handshake timeout.
module ysyx_23060332_seq_ctrl
  import ysyx_23060332_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             if_req_valid,
  input  logic             if_req_ready,
  input  logic             if_rsp_valid,
  output logic             ir_en,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_trap,
  input  logic             is_illegal,
  input  logic             reg_wen_i,
  output logic             reg_wen_o,
  output logic             pc_en,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_e       state_q;
  halt_cause_e      cause_q;
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  logic awaited;
  logic waiting;
  logic wd_exp;
  logic wd_run;
  logic timeout;
  logic leave;

  // The one input each handshake state is stalled on.
  always_comb begin
    awaited = 1'b0;
    unique case (state_q)
      SEQ_IF_REQ:   awaited = if_req_ready;
      SEQ_IF_WAIT:  awaited = if_rsp_valid;
      SEQ_MEM_REQ:  awaited = lsu_req_ready;
      SEQ_MEM_WAIT: awaited = lsu_rsp_valid;
      default:      awaited = 1'b0;
    endcase
  end

  assign waiting = is_wait_state(state_q);
  assign wd_run  = waiting & ~awaited;
  assign timeout = wd_run & wd_exp;
  assign leave   = (waiting & awaited) | timeout |
                   (state_q == SEQ_EXEC) | (state_q == SEQ_WB);

  ysyx_23060332_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (leave),
    .run    (wd_run),
    .expired(wd_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SEQ_IF_REQ;
      cause_q   <= HALT_NONE;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != SEQ_HALT)
        cycle_q <= cycle_q + CNT_ONE;
      unique case (state_q)
        SEQ_IF_REQ: begin
          if (awaited)
            state_q <= SEQ_IF_WAIT;
          else if (timeout) begin
            state_q <= SEQ_HALT;
            cause_q <= HALT_TIMEOUT;
          end
        end
        SEQ_IF_WAIT: begin
          if (awaited)
            state_q <= SEQ_EXEC;
          else if (timeout) begin
            state_q <= SEQ_HALT;
            cause_q <= HALT_TIMEOUT;
          end
        end
        // ebreak outranks illegal; it retires without a PC update.
        SEQ_EXEC: begin
          if (is_trap) begin
            state_q   <= SEQ_HALT;
            cause_q   <= HALT_EBREAK;
            instret_q <= instret_q + CNT_ONE;
          end else if (is_illegal) begin
            state_q <= SEQ_HALT;
            cause_q <= HALT_ILLEGAL;
          end else if (is_load || is_store)
            state_q <= SEQ_MEM_REQ;
          else
            state_q <= SEQ_WB;
        end
        SEQ_MEM_REQ: begin
          if (awaited)
            state_q <= SEQ_MEM_WAIT;
          else if (timeout) begin
            state_q <= SEQ_HALT;
            cause_q <= HALT_TIMEOUT;
          end
        end
        SEQ_MEM_WAIT: begin
          if (awaited)
            state_q <= SEQ_WB;
          else if (timeout) begin
            state_q <= SEQ_HALT;
            cause_q <= HALT_TIMEOUT;
          end
        end
        SEQ_WB: begin
          state_q   <= SEQ_IF_REQ;
          instret_q <= instret_q + CNT_ONE;
        end
        SEQ_HALT: state_q <= SEQ_HALT;
        default:  state_q <= SEQ_IF_REQ;
      endcase
    end
  end

  assign if_req_valid  = (state_q == SEQ_IF_REQ);
  assign lsu_req_valid = (state_q == SEQ_MEM_REQ);
  assign pc_en         = (state_q == SEQ_WB);
  assign reg_wen_o     = (state_q == SEQ_WB) & reg_wen_i;
  assign ir_en         = (state_q == SEQ_IF_WAIT) & if_rsp_valid;
  assign halted        = (state_q == SEQ_HALT);
  assign halt_cause    = cause_q;
  assign cycle_cnt     = cycle_q;
  assign instret_cnt   = instret_q;

endmodule

// File: doc/ysyx_23060332_seq_ctrl.md
# ysyx_23060332_seq_ctrl

Multi-cycle sequencer for the NPC core. It drives instruction fetch and LSU handshakes and gates register-file write-enable and PC update around the combinational decoder/execute path, so one instruction retires every few cycles. It also stops the core on ebreak, invalid instruction or bus timeout, and keeps cycle and retired-instruction counters for difftest/perf.

## Interface
- `TIMEOUT`, 255: max cycles waiting on any memory response before a bus error.
- `CNT_W`, 64: width of the cycle and instret counters.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req_valid`  out  1  fetch request to instruction memory (address = current PC, held externally).
- `if_req_ready`  in  1  imem accepts request.
- `if_rsp_valid`  in  1  instruction data valid.
- `ir_en`  out  1  load instruction register from imem data.
- `is_load` / `is_store`  in  1  decode class of the instruction in IR (opcode 0000011 / 0100011).
- `is_trap`  in  1  IR == ebreak (0x00100073).
- `is_illegal`  in  1  decoder flagged an invalid instruction.
- `reg_wen_i`  in  1  decoder write-enable.
- `reg_wen_o`  out  1  gated write-enable to the register file.
- `pc_en`  out  1  PC register loads next-PC.
- `lsu_req_valid`  out  1  data memory request.
- `lsu_req_ready`  in  1  LSU accepts request.
- `lsu_rsp_valid`  in  1  load data valid / store done.
- `halted`  out  1  core stopped.
- `halt_cause`  out  2  0 none, 1 ebreak, 2 illegal, 3 bus timeout.
- `cycle_cnt`  out  CNT_W  cycles since reset.
- `instret_cnt`  out  CNT_W  retired instructions.

## Operation
- States: IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT. Reset state is IF_REQ.
- IF_REQ: `if_req_valid`=1. On `if_req_ready`, go to IF_WAIT.
- IF_WAIT: on `if_rsp_valid`, `ir_en`=1 and go to EXEC.
- EXEC (decoder/ALU settle):
  - `is_trap`: go to HALT with cause 1.
  - Else `is_illegal`: go to HALT with cause 2.
  - Else `is_load` or `is_store`: go to MEM_REQ.
  - Else go to WB.
- MEM_REQ: `lsu_req_valid`=1. On `lsu_req_ready`, go to MEM_WAIT.
- MEM_WAIT: on `lsu_rsp_valid`, go to WB.
- WB: `reg_wen_o`=`reg_wen_i`, `pc_en`=1, `instret_cnt`+1, then go to IF_REQ.
- `reg_wen_o` is 0 in every other state. A store has `reg_wen_i`=0, so it never writes.
- HALT: terminal. All request and enable outputs are 0; `halted`=1; counters freeze. Only `rst` exits.
- ebreak retires (instret +1, no PC update) on entry to HALT. Illegal and timeout do not retire.
- Timeout counter:
  - Cleared on entry to IF_REQ, IF_WAIT, MEM_REQ and MEM_WAIT.
  - Increments in those states while the awaited signal is low.
  - When it reaches `TIMEOUT`, go to HALT with cause 3.
  - The awaited signal arriving in the same cycle the counter reaches `TIMEOUT` wins; no timeout.
- Response signals arriving in any state other than the one waiting for them are ignored.

## Timing
- Reset values: state IF_REQ, all outputs 0 except `if_req_valid`=1 (Moore output of IF_REQ); counters 0; `halt_cause` 0.
- All outputs are Moore, decoded from registered state. No combinational path from any input to `if_req_valid` / `lsu_req_valid`.
- `ir_en` is the one exception: it is `if_rsp_valid` & IF_WAIT, combinational.
- Minimum latency, zero-wait memory:
  - ALU instruction: 4 cycles (IF_REQ, IF_WAIT, EXEC, WB).
  - Load/store: 6 cycles.
- `cycle_cnt` increments every cycle outside HALT. It wraps at 2^CNT_W with no flag. `instret_cnt` follows the same wrap rule.
- Asserting `rst` mid-transaction drops all valids immediately. Memory-side state is the memory's responsibility.

## Structure
- State encoding and `halt_cause` codes go in the shared define file, as `SeqState*` / `HaltCause*` macros beside the existing `INST_*` definitions.
- The timeout counter is a natural sub-module, `ysyx_23060332_wdog`: ports clk, rst, clr, run, expired.
- The ebreak DPI call remains in the decoder. The sequencer only reports `halted`.

## Test plan
- ADDI with zero-wait imem (ready and rsp the cycle after request) -> `pc_en` and `reg_wen_o` high for exactly one cycle in cycle 4; `instret_cnt`=1 at cycle 5.
- LW with the LSU giving `lsu_req_ready` after 2 cycles and `lsu_rsp_valid` after 3 more -> WB at cycle 9; `reg_wen_o`=1 only in WB.
- SW -> full MEM path traversed; `reg_wen_o` never asserted; `pc_en` pulses once.
- IR=0x00100073 -> HALT, `halt_cause`=1, `instret_cnt` increments by 1, `cycle_cnt` frozen 10 cycles later.
- Illegal opcode 0x0000007F -> `halt_cause`=2, no retire. Then `if_rsp_valid` withheld for 255 cycles on a fresh run -> `halt_cause`=3; a response at cycle 255 proceeds normally.
- `rst` asserted in MEM_WAIT -> next edge: IF_REQ, `lsu_req_valid`=0, counters 0.
